// File: rtl/sync_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and sync-decode helper.
package sync_pkg;

   // Counter width for horizontal and vertical position
   localparam int CNT_W = 10;

   // Horizontal timing in pixel ticks
   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;

   // Vertical timing in lines
   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   // Derived totals and sync pulse windows (inclusive)
   localparam int H_TOTAL_DEF  = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int V_TOTAL_DEF  = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
   localparam int HS_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
   localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
   localparam int VS_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
   localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

   // True when a count lies inside an inclusive window
   function automatic logic in_range(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/sync_tick.sv
// Pixel-rate tick generator: one-cycle strobe every CLK_DIV system clocks.
module pix_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic CLK,
   input  logic RST,
   output logic TICK
);

   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

   logic [3:0] div_q;
   logic [3:0] div_d;

   // Next divider value and tick decode; tick is high while the divider sits at its last count
   always_comb begin
      div_d = div_q + 4'd1;
      if (div_q == DIV_LAST) begin
         div_d = '0;
      end
      TICK = (div_q == DIV_LAST);
   end

   // Divider register with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RST) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/sync.sv
// VGA sync generator: pixel/line counters plus registered active-low HS/VS.
module sync
   import sync_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int H_FRONT   = H_FRONT_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BACK    = H_BACK_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int V_FRONT   = V_FRONT_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BACK    = V_BACK_DEF,
   parameter int CLK_DIV   = 4
) (
   input  logic             CLK,
   input  logic             RST,
   output logic             HS,
   output logic             VS,
   output logic [CNT_W-1:0] ADDRH,
   output logic [CNT_W-1:0] ADDRV
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic             tick;
   logic [CNT_W-1:0] addrh_q, addrh_d;
   logic [CNT_W-1:0] addrv_q, addrv_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;

   pix_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .CLK  (CLK),
      .RST  (RST),
      .TICK (tick)
   );

   // Next counts on a pixel tick; syncs decode the next counts so they move with ADDRH/ADDRV
   always_comb begin
      addrh_d = addrh_q;
      addrv_d = addrv_q;
      if (tick) begin
         if (addrh_q == H_LAST) begin
            addrh_d = '0;
            if (addrv_q == V_LAST) begin
               addrv_d = '0;
            end else begin
               addrv_d = addrv_q + 1'b1;
            end
         end else begin
            addrh_d = addrh_q + 1'b1;
         end
      end
      hs_d = ~in_range(addrh_d, HS_START, HS_END);
      vs_d = ~in_range(addrv_d, VS_START, VS_END);
   end

   // Counter and sync registers; reset parks at origin with syncs inactive
   always_ff @(posedge CLK) begin
      if (!RST) begin
         addrh_q <= '0;
         addrv_q <= '0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
      end else begin
         addrh_q <= addrh_d;
         addrv_q <= addrv_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
      end
   end

   assign ADDRH = addrh_q;
   assign ADDRV = addrv_q;
   assign HS    = hs_q;
   assign VS    = vs_q;

endmodule

// File: tb/tb_sync.sv
// Directed bench for sync: default, CLK_DIV=1 and a shrunken-timing instance.
module tb_sync;
   import sync_pkg::*;

   logic clk = 1'b0;
   logic rst_a, rst_b, rst_c;
   logic hs4, vs4, hs1, vs1, hss, vss;
   logic [9:0] h4, v4, h1, v1, hsm, vsm;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   // Default timing, CLK_DIV = 4
   sync u_d4 (.CLK(clk), .RST(rst_a), .HS(hs4), .VS(vs4), .ADDRH(h4), .ADDRV(v4));

   // Default timing, CLK_DIV = 1
   sync #(.CLK_DIV(1)) u_d1 (.CLK(clk), .RST(rst_b), .HS(hs1), .VS(vs1), .ADDRH(h1), .ADDRV(v1));

   // Tiny timing: line 15 ticks (HS low 10..12), frame 10 lines (VS low 7..8), CLK_DIV = 2
   sync #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
          .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(2))
      u_sm (.CLK(clk), .RST(rst_c), .HS(hss), .VS(vss), .ADDRH(hsm), .ADDRV(vsm));

   typedef struct {
      int   n;
      int   h;
      int   v;
      logic hs;
      logic vs;
   } vec_t;

   vec_t tbl[10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int pack4(input int h, input int v, input logic hs, input logic vs);
      return (h << 12) | (v << 2) | (int'(hs) << 1) | int'(vs);
   endfunction

   initial begin
      int ti, err4, err1, errs, low4, fall_h, rise_h, wraps1, vlow_s;
      int eh, ev, t;
      logic ehs, evs, prev_hs4;
      logic [9:0] prev_h1;
      bit found;

      tbl[0] = '{3,    0,   0, 1'b1, 1'b1};
      tbl[1] = '{4,    1,   0, 1'b1, 1'b1};
      tbl[2] = '{7,    1,   0, 1'b1, 1'b1};
      tbl[3] = '{8,    2,   0, 1'b1, 1'b1};
      tbl[4] = '{2623, 655, 0, 1'b1, 1'b1};
      tbl[5] = '{2624, 656, 0, 1'b0, 1'b1};
      tbl[6] = '{3007, 751, 0, 1'b0, 1'b1};
      tbl[7] = '{3008, 752, 0, 1'b1, 1'b1};
      tbl[8] = '{3199, 799, 0, 1'b1, 1'b1};
      tbl[9] = '{3200, 0,   1, 1'b1, 1'b1};

      // Reset held for 5 cycles on all instances
      rst_a = 1'b0;
      rst_b = 1'b0;
      rst_c = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("reset_d4_c%0d", i), pack4(h4, v4, hs4, vs4), pack4(0, 0, 1'b1, 1'b1));
      end
      check("reset_d1", pack4(h1, v1, hs1, vs1), pack4(0, 0, 1'b1, 1'b1));
      check("reset_sm", pack4(hsm, vsm, hss, vss), pack4(0, 0, 1'b1, 1'b1));

      // Release all together; n counts edges since release
      rst_a = 1'b1;
      rst_b = 1'b1;
      rst_c = 1'b1;
      ti = 0; err4 = 0; err1 = 0; errs = 0; low4 = 0; fall_h = -1; rise_h = -1;
      wraps1 = 0; vlow_s = 0;
      prev_hs4 = 1'b1;
      prev_h1 = 10'd0;
      for (int n = 1; n <= 3200; n++) begin
         step();
         // Default instance: table vectors plus a per-cycle model
         if (ti < 10 && tbl[ti].n == n) begin
            check($sformatf("d4_vec_n%0d", n), pack4(h4, v4, hs4, vs4),
                  pack4(tbl[ti].h, tbl[ti].v, tbl[ti].hs, tbl[ti].vs));
            ti++;
         end
         eh  = (n / 4) % H_TOTAL_DEF;
         ev  = n / (4 * H_TOTAL_DEF);
         ehs = !(eh >= HS_START_DEF && eh <= HS_END_DEF);
         evs = !(ev >= VS_START_DEF && ev <= VS_END_DEF);
         if (pack4(h4, v4, hs4, vs4) != pack4(eh, ev, ehs, evs)) err4++;
         if (hs4 == 1'b0) low4++;
         if (prev_hs4 && !hs4) fall_h = int'(h4);
         if (!prev_hs4 && hs4) rise_h = int'(h4);
         prev_hs4 = hs4;

         // CLK_DIV = 1 instance
         eh  = n % 800;
         ev  = n / 800;
         ehs = !(eh >= 656 && eh <= 751);
         if (pack4(h1, v1, hs1, vs1) != pack4(eh, ev, ehs, 1'b1)) err1++;
         if (prev_h1 == 10'd799 && h1 == 10'd0) wraps1++;
         prev_h1 = h1;
         if (n == 1)   check("d1_first_tick", int'(h1), 1);
         if (n == 655) check("d1_hs_before", int'(hs1), 1);
         if (n == 656) check("d1_hs_fall", int'(hs1), 0);
         if (n == 751) check("d1_hs_last_low", int'(hs1), 0);
         if (n == 752) check("d1_hs_rise", int'(hs1), 1);
         if (n == 800) check("d1_line_wrap", pack4(h1, v1, hs1, vs1), pack4(0, 1, 1'b1, 1'b1));

         // Tiny-timing instance
         t   = n / 2;
         eh  = t % 15;
         ev  = (t / 15) % 10;
         ehs = !(eh >= 10 && eh <= 12);
         evs = !(ev >= 7 && ev <= 8);
         if (pack4(hsm, vsm, hss, vss) != pack4(eh, ev, ehs, evs)) errs++;
         if (n <= 300 && vss == 1'b0) vlow_s++;
         if (n == 299) check("sm_frame_last", pack4(hsm, vsm, hss, vss), pack4(14, 9, 1'b1, 1'b1));
         if (n == 300) check("sm_frame_wrap", pack4(hsm, vsm, hss, vss), pack4(0, 0, 1'b1, 1'b1));
      end
      check("d4_line_model_errors", err4, 0);
      check("d4_hs_low_cycles", low4, 384);
      check("d4_hs_fall_at", fall_h, 656);
      check("d4_hs_rise_at", rise_h, 752);
      check("d1_line_model_errors", err1, 0);
      check("d1_line_wraps", wraps1, 4);
      check("sm_frame_model_errors", errs, 0);
      check("sm_vs_low_cycles", vlow_s, 60);

      // Reset in the middle of both sync pulses on the tiny instance
      found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         step();
         found = (hsm == 10'd11 && vsm == 10'd8);
      end
      check("sm_wait_both_sync", int'(found), 1);
      check("sm_syncs_low_before_rst", pack4(0, 0, hss, vss), pack4(0, 0, 1'b0, 1'b0));
      rst_c = 1'b0;
      step();
      check("sm_rst_mid_sync", pack4(hsm, vsm, hss, vss), pack4(0, 0, 1'b1, 1'b1));
      rst_c = 1'b1;

      // Reset mid-HS-pulse on the default instance
      found = 1'b0;
      for (int k = 0; k < 4000 && !found; k++) begin
         step();
         found = (h4 == 10'd700);
      end
      check("d4_wait_h700", int'(found), 1);
      check("d4_hs_low_at_700", int'(hs4), 0);
      rst_a = 1'b0;
      step();
      check("d4_rst_mid_hs", pack4(h4, v4, hs4, vs4), pack4(0, 0, 1'b1, 1'b1));
      rst_a = 1'b1;
      for (int k = 0; k < 3; k++) step();
      check("d4_rerelease_hold", int'(h4), 0);
      step();
      check("d4_rerelease_tick", int'(h4), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
